// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter
// ---------------------------------------------------------------------------
// Two-master / one-slave arbiter for the native memory bus. Master 0 is the
// instruction bus and master 1 is the data bus. Both share one slave port.
// The grant is held for the whole transaction, until the slave returns
// ready. A watchdog aborts a transaction that is never acknowledged.
//
// Bus layout:
//   request  (`REQ_W)  MSB..LSB: valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]
//   response (`RESP_W) MSB..LSB: rdata[DATA_W], ready
//
// Ports:
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   m0_req/m0_resp master 0 (instruction bus) request / response
//   m1_req/m1_resp master 1 (data bus) request / response
//   s_req/s_resp   shared slave request / response
//   timeout        one-cycle pulse when a transaction is aborted
//   timeout_sticky set by timeout; only reset clears it
//
// Configuration macro ARB_ROUND_ROBIN_EN:
//   defined   - round-robin. On a tie, the master other than the last one
//               served wins.
//   undefined - fixed priority. Master 1 wins ties and there is no 'last'
//               register.
// ---------------------------------------------------------------------------
`ifndef REQ_W
`define REQ_W (1 + ADDR_W + DATA_W + DATA_W / 8)
`endif
`ifndef RESP_W
`define RESP_W (DATA_W + 1)
`endif

module iob_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [`REQ_W-1:0]  m0_req,
    output logic [`RESP_W-1:0] m0_resp,
    input  logic [`REQ_W-1:0]  m1_req,
    output logic [`RESP_W-1:0] m1_resp,
    output logic [`REQ_W-1:0]  s_req,
    input  logic [`RESP_W-1:0] s_resp,
    output logic               timeout,
    output logic               timeout_sticky
);

    localparam int REQ_W  = `REQ_W;
    localparam int RESP_W = `RESP_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);

    logic [0:0]           state_r, state_n_s;
    logic                 gnt_r, gnt_n_s;
    logic [TIMEOUT_W-1:0] wdog_r, wdog_n_s;
    logic                 sticky_r;
`ifdef ARB_ROUND_ROBIN_EN
    logic                 last_r;
`endif

    logic              m0_valid_s, m1_valid_s;
    logic              s_ready_s;
    logic [DATA_W-1:0] s_rdata_s;
    logic              win_s, owner_s, owner_valid_s;
    logic              wdog_full_s, active_s, complete_s, abort_s, drop_s;

    assign m0_valid_s = m0_req[REQ_W-1];
    assign m1_valid_s = m1_req[REQ_W-1];
    assign s_ready_s  = s_resp[0];
    assign s_rdata_s  = s_resp[RESP_W-1:1];

    // Winner selection for the IDLE state
`ifdef ARB_ROUND_ROBIN_EN
    assign win_s = (m0_valid_s && m1_valid_s) ? ~last_r : m1_valid_s;
`else
    assign win_s = m1_valid_s;
`endif

    // In IDLE the combinational winner owns the bus. In BUSY the stored grant
    // owns it. Forwarding is gated with resetn so the slave sees an idle bus
    // as soon as reset asserts, without waiting for an edge. At the watchdog
    // limit the request is withdrawn without looking at s_resp. That keeps
    // the path from s_req back to s_resp free of combinational loops.
    assign owner_s       = (state_r == ST_IDLE) ? win_s : gnt_r;
    assign owner_valid_s = owner_s ? m1_valid_s : m0_valid_s;
    assign wdog_full_s   = (state_r == ST_BUSY) && (wdog_r == WDOG_MAX);
    assign active_s      = resetn && owner_valid_s && !wdog_full_s;
    assign complete_s    = active_s && s_ready_s;
    assign abort_s       = resetn && wdog_full_s && owner_valid_s;
    assign drop_s        = (state_r == ST_BUSY) && !owner_valid_s;
    assign timeout        = abort_s;
    assign timeout_sticky = sticky_r;

    // Request forwarding and response routing
    always_comb begin
        s_req   = {REQ_W{1'b0}};
        m0_resp = {RESP_W{1'b0}};
        m1_resp = {RESP_W{1'b0}};
        if (active_s) begin
            s_req = owner_s ? m1_req : m0_req;
        end else begin
            s_req = {REQ_W{1'b0}};
        end
        if (complete_s) begin
            if (owner_s) begin
                m1_resp = {s_rdata_s, 1'b1};
            end else begin
                m0_resp = {s_rdata_s, 1'b1};
            end
        end else if (abort_s) begin
            if (owner_s) begin
                m1_resp = {{DATA_W{1'b0}}, 1'b1};
            end else begin
                m0_resp = {{DATA_W{1'b0}}, 1'b1};
            end
        end else begin
            m0_resp = {RESP_W{1'b0}};
            m1_resp = {RESP_W{1'b0}};
        end
    end

    // Next-state, grant and watchdog logic. The watchdog counts the issuing
    // IDLE cycle as well, so an abort falls on occupancy cycle 2^TIMEOUT_W.
    always_comb begin
        state_n_s = state_r;
        gnt_n_s   = gnt_r;
        wdog_n_s  = wdog_r;
        case (state_r)
            ST_IDLE: begin
                if (active_s && !s_ready_s) begin
                    state_n_s = ST_BUSY;
                    gnt_n_s   = win_s;
                    wdog_n_s  = WDOG_ONE;
                end else begin
                    state_n_s = ST_IDLE;
                    wdog_n_s  = WDOG_ZERO;
                end
            end
            ST_BUSY: begin
                if (complete_s || abort_s || drop_s) begin
                    state_n_s = ST_IDLE;
                    wdog_n_s  = WDOG_ZERO;
                end else if (wdog_r != WDOG_MAX) begin
                    wdog_n_s  = wdog_r + WDOG_ONE;
                end else begin
                    wdog_n_s  = wdog_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                wdog_n_s  = WDOG_ZERO;
            end
        endcase
    end

    // State, grant, watchdog and sticky-timeout registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            gnt_r    <= 1'b0;
            wdog_r   <= WDOG_ZERO;
            sticky_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            gnt_r   <= gnt_n_s;
            wdog_r  <= wdog_n_s;
            if (abort_s) begin
                sticky_r <= 1'b1;
            end else begin
                sticky_r <= sticky_r;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-served master. The reset value of 1 makes master 0 win the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_r <= 1'b1;
        end else if (complete_s || abort_s) begin
            last_r <= owner_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

endmodule

// File: doc/iob_mem_arbiter.md
# iob_mem_arbiter

Two-master, one-slave arbiter for the native memory bus. It lets the CPU instruction bus and data bus share a single memory port, such as one SRAM or the DDR cache front-end. It holds the grant for the whole transaction until the slave returns ready. A watchdog aborts transactions that the slave never acknowledges.

## Interface

Bus field layout:
- Request, MSB to LSB: valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]. Width is `REQ_W.
- Response, MSB to LSB: rdata[DATA_W], ready. Width is `RESP_W.

Parameters:
- ADDR_W, 32, address field width.
- DATA_W, 32, data field width. wstrb is DATA_W/8 bits wide.
- TIMEOUT_W, 8, watchdog counter width. The abort limit is 2^TIMEOUT_W-1 cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req  in  `REQ_W  master 0 request (instruction bus).
- m0_resp  out  `RESP_W  master 0 response.
- m1_req  in  `REQ_W  master 1 request (data bus).
- m1_resp  out  `RESP_W  master 1 response.
- s_req  out  `REQ_W  request to the shared slave.
- s_resp  in  `RESP_W  response from the shared slave.
- timeout  out  1  one-cycle pulse when a transaction is aborted.
- timeout_sticky  out  1  set by timeout; cleared only by reset.

## Operation

- States are IDLE and BUSY. Registers:
  - gnt: 1 bit, the owning master.
  - last: 1 bit, the master served most recently.
  - wdog: TIMEOUT_W bits, the watchdog counter.
- Masters hold valid and the payload stable until they receive ready; the PicoRV32 native protocol guarantees this.
- IDLE:
  - If any valid is high, a winner is selected combinationally per the configured policy.
  - The winner's request is forwarded to s_req in the same cycle.
  - If s_resp.ready is already high in that cycle, the transaction completes and the state stays IDLE. Otherwise the state moves to BUSY with gnt set to the winner.
- BUSY:
  - s_req = request of master gnt. The other master sees ready=0 and rdata=0.
  - s_resp.ready high: ready and rdata are routed to master gnt, last is set to gnt, and the state returns to IDLE.
  - Master gnt drops valid before ready (protocol violation): s_req.valid goes to 0 and the state returns to IDLE on the next edge. No response is delivered.
  - wdog reaches 2^TIMEOUT_W-1 without ready:
    - master gnt receives ready=1, rdata=0;
    - timeout pulses and timeout_sticky is set;
    - s_req.valid goes to 0 in that cycle;
    - the state returns to IDLE.
- wdog clears in IDLE and increments once per BUSY cycle; it never wraps.
- When nothing is granted, s_req is all zeros.
- Simultaneous requests in IDLE are resolved by the policy. The loser waits, stalled, and is considered in the IDLE cycle after completion. There is no dead cycle between back-to-back grants.
- Reset (asynchronous, any time including mid-transaction):
  - state = IDLE, gnt = 0, last = 1 (so master 0 wins first), wdog = 0;
  - timeout = 0, timeout_sticky = 0;
  - s_req.valid = 0 and both resp.ready = 0 immediately, without waiting for a clock edge.

## Timing

- Added request latency is 0 cycles: s_req follows the winner combinationally in IDLE.
- Response latency is 0 cycles: s_resp is routed combinationally to master gnt.
- A transaction with a single-cycle slave takes 1 cycle.
- A slave with N wait cycles occupies the arbiter for N+1 cycles.
- The maximum occupancy before an abort is 2^TIMEOUT_W cycles.
- After master A completes in cycle t, master B can be granted in cycle t+1.

## Configuration

- The macro is ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On a tie, the master other than last wins, so alternating requesters strictly alternate.
- Undefined: fixed priority. Master 1 (data) always wins ties, and the last register is not implemented.
- The policy applies only in IDLE. A grant is never preempted, under either setting.

## Test plan

- Single request, wait-free slave: m0 reads 0x100, slave returns rdata=0xDEADBEEF with ready in the same cycle → m0_resp ready=1, rdata=0xDEADBEEF in that cycle; m1_resp ready=0; state stays IDLE.
- Tie, ARB_ROUND_ROBIN_EN defined: both masters request continuously and the slave has 2 wait cycles → grants alternate m0, m1, m0, m1, each transaction lasting 3 cycles. Without the macro, m1 is served every time while m1 keeps requesting.
- Write passthrough: m1 writes wdata=0x12345678, wstrb=4'b0011 to 0x2000 while m0 is idle → s_req carries exactly these fields; m0_resp stays 0.
- Watchdog: TIMEOUT_W=4 and the slave never asserts ready → in cycle 15 of BUSY, m0 gets ready=1, rdata=0 and timeout pulses for 1 cycle. timeout_sticky stays 1 until resetn=0.
- Reset mid-transaction: resetn goes low 2 cycles into a BUSY m1 transaction → s_req.valid = 0 asynchronously and all outputs are 0. After release, a tie grants m0 first.
- Valid dropped: m0 deasserts valid in BUSY → s_req.valid = 0 and the state returns to IDLE on the next edge, with no ready to either master. A pending m1 request is granted in the following cycle.
